// File: rtl/loader_pkg.sv
// Shared types and framing constants for the boot-time instruction loader.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_WRITE,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } loader_state_e;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_assembler.sv
// Shifts stream bytes MSB-first into a 32-bit word and keeps a running XOR
// of every byte shifted in.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_next_o,
   output logic        word_full_o,
   output logic [7:0]  csum_o
);

   logic [31:0]      word_q, word_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       csum_q, csum_d;

   // Word as it will look once the current byte is shifted in.
   assign word_next_o = {word_q[23:0], byte_i};
   // High while the next shift completes a word; the counter wraps to 0 then.
   assign word_full_o = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
   assign csum_o      = csum_q;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      csum_d = csum_q;
      if (clear_i) begin
         word_d = '0;
         cnt_d  = '0;
         csum_d = '0;
      end else if (shift_i) begin
         word_d = word_next_o;
         cnt_d  = cnt_q + CNT_W'(1);
         csum_d = csum_q ^ byte_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q <= '0;
         cnt_q  <= '0;
         csum_q <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
         csum_q <= csum_d;
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a length/data/checksum byte frame, writes one word per
// cycle-strobe into instruction memory and holds the CPU until a clean load.
module instr_loader
   import loader_pkg::*;
#(
   parameter int          WORDS     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [7:0]    byte_i,
   input  logic          byte_valid_i,
   output logic          byte_ready_o,
   output logic          memWriteEnable_o,
   output logic [31:0]   memAddress_o,
   output logic [31:0]   memData_o,
   output logic          cpuHold_o,
   output logic          done_o,
   output logic          error_o,
   output loader_state_e state_o
);

   // Handshake: a byte transfers on a rising edge where byte_valid_i and
   // byte_ready_o are both high; byte_ready_o depends on state only.

   localparam logic [16:0] WORDS_L = 17'(WORDS);

   loader_state_e state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   idx_q, idx_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;

   logic          accept;
   logic          asm_clear;
   logic          asm_shift;
   logic [31:0]   asm_word_next;
   logic          asm_word_full;
   logic [7:0]    asm_csum;
   logic [15:0]   len_full;
   logic [15:0]   idx_inc;

   word_assembler u_asm (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (asm_clear),
      .shift_i     (asm_shift),
      .byte_i      (byte_i),
      .word_next_o (asm_word_next),
      .word_full_o (asm_word_full),
      .csum_o      (asm_csum)
   );

   assign byte_ready_o     = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                             (state_q == ST_DATA)   || (state_q == ST_CHECK);
   assign memWriteEnable_o = (state_q == ST_WRITE);
   assign cpuHold_o        = (state_q != ST_DONE);
   assign done_o           = (state_q == ST_DONE);
   assign error_o          = (state_q == ST_ERROR);
   assign memAddress_o     = addr_q;
   assign memData_o        = data_q;
   assign state_o          = state_q;

   assign accept   = byte_valid_i && byte_ready_o;
   assign len_full = {len_q[15:8], byte_i};
   assign idx_inc  = idx_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      data_d    = data_q;
      asm_clear = 1'b0;
      asm_shift = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_i) begin
               state_d   = ST_LEN_HI;
               len_d     = '0;
               idx_d     = '0;
               asm_clear = 1'b1;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = byte_i;
               state_d     = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_d = len_full;
               if (len_full == 16'd0 || {1'b0, len_full} > WORDS_L)
                  state_d = ST_ERROR;
               else
                  state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (accept) begin
               asm_shift = 1'b1;
               // Capture the finished word so it is stable during the strobe.
               if (asm_word_full) begin
                  data_d  = asm_word_next;
                  addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            idx_d   = idx_inc;
            state_d = (idx_inc == len_q) ? ST_CHECK : ST_DATA;
         end
         ST_CHECK: begin
            if (accept)
               state_d = (byte_i == asm_csum) ? ST_DONE : ST_ERROR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table of frames plus reset/restart
// sequences; write strobes are checked against a queue of expected writes.
module tb_instr_loader;
   import loader_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic          clk;
   logic          rst_i;
   logic          start_i;
   logic [7:0]    byte_i;
   logic          byte_valid_i;
   logic          byte_ready_o;
   logic          memWriteEnable_o;
   logic [31:0]   memAddress_o;
   logic [31:0]   memData_o;
   logic          cpuHold_o;
   logic          done_o;
   logic          error_o;
   loader_state_e state_o;

   instr_loader #(.WORDS(256), .BASE_ADDR(BASE)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .start_i          (start_i),
      .byte_i           (byte_i),
      .byte_valid_i     (byte_valid_i),
      .byte_ready_o     (byte_ready_o),
      .memWriteEnable_o (memWriteEnable_o),
      .memAddress_o     (memAddress_o),
      .memData_o        (memData_o),
      .cpuHold_o        (cpuHold_o),
      .done_o           (done_o),
      .error_o          (error_o),
      .state_o          (state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q[$];
   int          n_cmp    = 0;
   int          n_err    = 0;
   int          n_writes = 0;
   bit          mon_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst_i && memWriteEnable_o) begin
         logic [63:0] e;
         n_writes++;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {memAddress_o, memData_o}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", {32'd0, memAddress_o}, {32'd0, e[63:32]});
            chk("write_data", {32'd0, memData_o}, {32'd0, e[31:0]});
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [127:0] bytes;      // frame bytes, first byte most significant
      int           n;
      bit           gaps;
      int           start_at;   // pulse start_i before this byte index, -1 none
      bit           exp_done;
      bit           exp_err;
      int           exp_writes;
   } vec_t;

   vec_t tbl[8];

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int guard;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      byte_i       = b;
      byte_valid_i = 1'b1;
      guard        = 0;
      while (!byte_ready_o && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk("ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      byte_valid_i = 1'b0;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("start_state", {61'd0, state_o}, {61'd0, ST_LEN_HI});
      chk("start_hold",  {63'd0, cpuHold_o}, 64'd1);
      chk("start_done",  {63'd0, done_o}, 64'd0);
      chk("start_err",   {63'd0, error_o}, 64'd0);
      chk("start_ready", {63'd0, byte_ready_o}, 64'd1);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [127:0] bv;
      logic [31:0]  w;
      logic [7:0]   b;
      int           w0;
      bv = v.bytes;
      w  = '0;
      w0 = n_writes;
      do_start();
      for (int i = 0; i < v.n; i++) begin
         b = bv[(v.n-1-i)*8 +: 8];
         if (i == v.start_at) pulse_start();
         if (i >= HDR_BYTES && i < v.n - 1) begin
            w = {w[23:0], b};
            if ((i - HDR_BYTES) % BYTES_PER_WORD == BYTES_PER_WORD - 1)
               exp_q.push_back({BASE + 32'(4 * ((i - HDR_BYTES) / BYTES_PER_WORD)), w});
         end
         send_byte(b, v.gaps);
      end
      chk("end_done",   {63'd0, done_o}, {63'd0, v.exp_done});
      chk("end_err",    {63'd0, error_o}, {63'd0, v.exp_err});
      chk("end_hold",   {63'd0, cpuHold_o}, {63'd0, !v.exp_done});
      chk("end_ready",  {63'd0, byte_ready_o}, 64'd0);
      chk("end_writes", 64'(n_writes - w0), 64'(v.exp_writes));
      chk("end_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int w0;
      tbl[0] = '{88'h0002_2008_0005_0109_5020_55, 11, 1'b0, -1, 1'b1, 1'b0, 2};
      tbl[1] = '{88'h0002_2008_0005_0109_5020_54, 11, 1'b0, -1, 1'b0, 1'b1, 2};
      tbl[2] = '{16'h0000,                         2, 1'b0, -1, 1'b0, 1'b1, 0};
      tbl[3] = '{16'h0101,                         2, 1'b0, -1, 1'b0, 1'b1, 0};
      tbl[4] = '{56'h0001_DEAD_BEEF_22,            7, 1'b0, -1, 1'b1, 1'b0, 1};
      tbl[5] = '{88'h0002_2008_0005_0109_5020_55, 11, 1'b1, -1, 1'b1, 1'b0, 2};
      tbl[6] = '{88'h0002_2008_0005_0109_5020_55, 11, 1'b0,  4, 1'b1, 1'b0, 2};
      tbl[7] = '{120'h0003_1122_3344_A55A_0FF0_8000_0001_C5, 15, 1'b1, -1, 1'b1, 1'b0, 3};

      rst_i        = 1'b1;
      start_i      = 1'b0;
      byte_i       = 8'h00;
      byte_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_hold",  {63'd0, cpuHold_o}, 64'd1);
      chk("rst_ready", {63'd0, byte_ready_o}, 64'd0);
      chk("rst_we",    {63'd0, memWriteEnable_o}, 64'd0);
      chk("rst_done",  {63'd0, done_o}, 64'd0);
      chk("rst_err",   {63'd0, error_o}, 64'd0);
      chk("rst_addr",  {32'd0, memAddress_o}, 64'd0);
      chk("rst_data",  {32'd0, memData_o}, 64'd0);
      chk("rst_state", {61'd0, state_o}, {61'd0, ST_IDLE});
      rst_i  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 8; k++) run_vec(tbl[k]);

      // Reset after the 3rd data byte: no write, async clear of registers.
      w0 = n_writes;
      do_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h08, 1'b0);
      send_byte(8'h00, 1'b0);
      #2 rst_i = 1'b1;
      #1;
      chk("mid_rst_hold",  {63'd0, cpuHold_o}, 64'd1);
      chk("mid_rst_ready", {63'd0, byte_ready_o}, 64'd0);
      chk("mid_rst_addr",  {32'd0, memAddress_o}, 64'd0);
      chk("mid_rst_data",  {32'd0, memData_o}, 64'd0);
      chk("mid_rst_state", {61'd0, state_o}, {61'd0, ST_IDLE});
      @(negedge clk);
      rst_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rst_nowrite", 64'(n_writes - w0), 64'd0);
      chk("mid_rst_idle",    {61'd0, state_o}, {61'd0, ST_IDLE});
      run_vec(tbl[0]);

      // Restart from DONE.
      do_start();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader: the write side of the instruction memory port, which the datapath only ever reads. It accepts a framed byte stream (length header, big-endian instruction words, XOR checksum) and assembles 32-bit words. It issues one write per word into instruction memory and holds the processor in reset until a load completes cleanly. It sits between the host byte link and the instruction memory write port, and drives the hold input of `PC`/datapath reset.

## Interface

**Parameters**
- `WORDS`, default 256: instruction memory depth in words; the maximum legal length header.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.

**Ports**
- `clk_i`  in  1  single clock; all state on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  begin a load session; honoured only in IDLE, DONE or ERROR.
- `byte_i`  in  8  stream byte.
- `byte_valid_i`  in  1  `byte_i` is valid.
- `byte_ready_o`  out  1  loader accepts a byte this cycle. Transfer occurs when valid & ready.
- `memWriteEnable_o`  out  1  one-cycle write strobe to instruction memory.
- `memAddress_o`  out  32  byte address: `BASE_ADDR` + 4·index.
- `memData_o`  out  32  assembled instruction word.
- `cpuHold_o`  out  1  keeps the PC/datapath in reset while high.
- `done_o`  out  1  last session completed with a good checksum.
- `error_o`  out  1  last session failed (bad length or bad checksum).

## Operation

**Frame format:** `LEN_HI`, `LEN_LO` (word count N, big-endian), then 4·N data bytes (each word MSB first), then one checksum byte equal to the XOR of all 4·N data bytes. Length bytes are not included in the checksum.

**States:** IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR.
- **IDLE**
  - `start_i` → LEN_HI. Clears word index, byte count, checksum accumulator, `done_o` and `error_o`.
- **LEN_HI**
  - Accept → latch N[15:8], go to LEN_LO.
- **LEN_LO**
  - Accept → latch N[7:0].
  - If N==0 or N>`WORDS` → ERROR; else → DATA.
- **DATA**
  - Each accepted byte is shifted into the word register (new byte enters bits [7:0]) and XORed into the accumulator.
  - The 4th accepted byte → WRITE.
- **WRITE**
  - `memWriteEnable_o`=1 for exactly one cycle, with `memAddress_o` = `BASE_ADDR` + 4·index and `memData_o` = assembled word.
  - Index increments. If the new index equals N → CHECK; else → DATA with byte count cleared.
- **CHECK**
  - Accept one byte. Equal to the accumulator → DONE; else → ERROR.
- **DONE**
  - `done_o`=1 and `cpuHold_o`=0. Remains until `start_i`, which goes to LEN_HI.
- **ERROR**
  - `error_o`=1 and `cpuHold_o`=1. Remains until `start_i`, which goes to LEN_HI.

**Output rules:**
- `byte_ready_o`=1 exactly in LEN_HI, LEN_LO, DATA and CHECK.
- `cpuHold_o`=1 in every state except DONE.
- `start_i` in LEN_HI, LEN_LO, DATA, WRITE or CHECK is ignored.
- Words already written before a checksum failure are not rolled back; ERROR keeps the CPU held.
- The index counter is 16 bits. Address arithmetic is 32-bit modulo with no wrap checking; N ≤ `WORDS` bounds it.

## Timing

**Reset** (asynchronous, immediate): state IDLE, `cpuHold_o`=1. All other outputs are 0: `byte_ready_o`, `memWriteEnable_o`, `done_o`, `error_o`, `memAddress_o`=0, `memData_o`=0. Counters and accumulator are 0.

**Reset mid-session:** abandons the frame. A partially assembled word is never written.

**Cycle behaviour:**
- One byte per cycle maximum. Gaps in `byte_valid_i` stall the FSM with no timeout.
- The write strobe occurs the cycle after the 4th byte of a word is accepted. `byte_ready_o` is 0 during that cycle.
- Minimum 5 cycles per word. Minimum frame time is 2 + 5·N + 1 cycles after `start_i`.
- `done_o`/`error_o` assert the cycle after the checksum byte is accepted, or after `LEN_LO` for a length error. `cpuHold_o` deasserts in that same cycle for DONE.
- `memAddress_o`/`memData_o` are registered and hold their last value outside WRITE.

## Structure

- **Shared package `loader_pkg`:**
  - state enum;
  - `HDR_BYTES`=2, `BYTES_PER_WORD`=4 constants.
- **Sub-module `word_assembler`:**
  - 32-bit shift register;
  - 2-bit byte counter with `word_full` flag;
  - 8-bit XOR accumulator;
  - clear input.
- **`instr_loader`** keeps the FSM, length/index counters and output registers.

## Test plan

1. **Reset:** assert `rst_i` asynchronously mid-cycle → `cpuHold_o`=1 immediately; all other outputs 0; `byte_ready_o`=0.
2. **Good load:** `start_i`, then bytes 00 02 | 20 08 00 05 | 01 09 50 20 | 55 →
   - writes (addr 0x0, 0x20080005) and (addr 0x4, 0x01095020), one cycle each;
   - then `done_o`=1, `cpuHold_o`=0.
3. **Bad checksum:** same frame with checksum 0x54 → both writes occur, then `error_o`=1, `cpuHold_o`=1, `done_o`=0.
4. **Bad length:** header 00 00, and separately header 01 01 with `WORDS`=256 → ERROR the cycle after `LEN_LO`; no write strobes.
5. **Gaps and reset:** random `byte_valid_i` gaps during a good load give the same writes and the same DONE. Asserting `rst_i` after the 3rd data byte gives IDLE with no write; a fresh session then completes correctly.
6. **Restart:** `start_i` pulsed during DATA is ignored (the frame completes normally). `start_i` in DONE → `cpuHold_o`=1 and `done_o`=0 the next cycle; state LEN_HI.
